// File: rtl/tlb_pkg.sv
// Shared types, constants and match helpers for the multi-port TLB.
package tlb_pkg;

    typedef enum logic [1:0] {
        OP_TLBWI  = 2'b00,
        OP_TLBWR  = 2'b01,
        OP_TLBP   = 2'b10,
        OP_INVALL = 2'b11
    } tlb_op_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } tlb_state_t;

    typedef struct packed {
        logic [11:0] mask;
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [19:0] pfn1;
        logic [2:0]  c0;
        logic [2:0]  c1;
        logic        d0;
        logic        d1;
        logic        v0;
        logic        v1;
    } tlb_entry_t;

    localparam logic [2:0] CCA_RESET   = 3'd3;
    localparam int         EXC_MISS    = 2;
    localparam int         EXC_INVALID = 1;
    localparam int         EXC_CLEAN   = 0;

    localparam tlb_entry_t ENTRY_RESET = '{
        mask: 12'h000, vpn2: 19'h00000, asid: 8'h00, g: 1'b0,
        pfn0: 20'h00000, pfn1: 20'h00000, c0: CCA_RESET, c1: CCA_RESET,
        d0: 1'b0, d1: 1'b0, v0: 1'b0, v1: 1'b0
    };

    // live is cleared by reset and by the invalidate sweep; only writes set it
    function automatic logic tlb_match(input tlb_entry_t e, input logic live,
                                       input logic [31:0] va, input logic [7:0] asid);
        logic [18:0] m;
        m = {7'b0000000, e.mask};
        return live && ((va[31:13] & ~m) == (e.vpn2 & ~m)) && (e.g || (e.asid == asid));
    endfunction

    function automatic logic odd_sel(input logic [31:0] va, input logic [11:0] mask);
        logic b;
        b = va[12];
        for (int i = 0; i < 12; i++) begin
            b = mask[i] ? va[13+i] : b;
        end
        return b;
    endfunction

    function automatic logic [31:0] off_mask(input logic [11:0] mask);
        return {8'h00, mask, 12'hfff};
    endfunction

endpackage

// File: rtl/tlb_lookup_port.sv
// One translation port: associative match, even/odd page select, registered result.
import tlb_pkg::*;

module tlb_lookup_port #(
    parameter int TLB_NUM = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          va,
    input  logic [7:0]           asid,
    input  logic                 stall,
    input  logic                 flush,
    input  tlb_entry_t           entries [TLB_NUM],
    input  logic [TLB_NUM-1:0]   live,
    output logic [31:0]          pa,
    output logic [2:0]           exc,
    output logic [2:0]           cca
);

    logic        hit_s;
    logic        odd_s;
    tlb_entry_t  sel_s;
    logic [31:0] om_s;
    logic [31:0] nxt_pa_s;
    logic [2:0]  nxt_exc_s;
    logic [2:0]  nxt_cca_s;
    logic        unused_s;

    assign unused_s = ^{sel_s.vpn2, sel_s.asid, sel_s.g};

    // Lowest matching index wins; then build the translated result
    always_comb begin
        hit_s     = 1'b0;
        sel_s     = ENTRY_RESET;
        nxt_pa_s  = 32'h0000_0000;
        nxt_exc_s = 3'b000;
        nxt_cca_s = 3'd0;
        for (int i = TLB_NUM - 1; i >= 0; i--) begin
            if (tlb_match(entries[i], live[i], va, asid)) begin
                hit_s = 1'b1;
                sel_s = entries[i];
            end else begin
                hit_s = hit_s;
            end
        end
        odd_s = odd_sel(va, sel_s.mask);
        om_s  = off_mask(sel_s.mask);
        if (hit_s) begin
            nxt_pa_s               = ({(odd_s ? sel_s.pfn1 : sel_s.pfn0), 12'h000} & ~om_s) | (va & om_s);
            nxt_exc_s[EXC_INVALID] = ~(odd_s ? sel_s.v1 : sel_s.v0);
            nxt_exc_s[EXC_CLEAN]   = ~(odd_s ? sel_s.d1 : sel_s.d0);
            nxt_cca_s              = odd_s ? sel_s.c1 : sel_s.c0;
        end else begin
            nxt_exc_s[EXC_MISS]    = 1'b1;
            nxt_exc_s[EXC_CLEAN]   = 1'b1;
        end
    end

    // Result register: flush beats stall beats update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pa  <= 32'h0000_0000;
            exc <= 3'b000;
            cca <= CCA_RESET;
        end else if (flush) begin
            pa  <= 32'h0000_0000;
            exc <= 3'b000;
            cca <= CCA_RESET;
        end else if (stall) begin
            pa  <= pa;
            exc <= exc;
            cca <= cca;
        end else begin
            pa  <= nxt_pa_s;
            exc <= nxt_exc_s;
            cca <= nxt_cca_s;
        end
    end

endmodule

// File: rtl/tlb_multiport.sv
// Multi-port TLB: shared entry array, maintenance command FSM, Random/probe registers.
import tlb_pkg::*;

module tlb_multiport #(
    parameter int TLB_NUM  = 32,
    parameter int IDX_BITS = $clog2(TLB_NUM),
    parameter int NPORTS   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    input  logic [1:0]            cmd_op,
    output logic                  cmd_ready,
    input  logic [IDX_BITS-1:0]   index_i,
    input  logic [IDX_BITS-1:0]   wired_i,
    input  logic [11:0]           mask_i,
    input  logic [31:0]           entryhi_i,
    input  logic [31:0]           entrylo0_i,
    input  logic [31:0]           entrylo1_i,
    output logic [11:0]           mask_o,
    output logic [31:0]           entryhi_o,
    output logic [31:0]           entrylo0_o,
    output logic [31:0]           entrylo1_o,
    output logic [31:0]           probe_index_o,
    output logic [IDX_BITS-1:0]   random_o,
    input  logic [NPORTS*32-1:0]  lk_va_i,
    input  logic [NPORTS-1:0]     lk_stall_i,
    input  logic [NPORTS-1:0]     lk_flush_i,
    output logic [NPORTS*32-1:0]  lk_pa_o,
    output logic [NPORTS*3-1:0]   lk_exc_o,
    output logic [NPORTS*3-1:0]   lk_cca_o,
    output logic                  multi_hit_o
);

    localparam logic [IDX_BITS-1:0] LAST = IDX_BITS'(TLB_NUM - 1);

    tlb_state_t          state_r, state_s;
    tlb_entry_t          entries_r [TLB_NUM];
    logic [TLB_NUM-1:0]  live_r;
    logic [IDX_BITS-1:0] sweep_cnt_r;
    logic [IDX_BITS-1:0] random_r;
    logic [31:0]         probe_r;
    logic                multi_r;
    logic                we_s, probe_en_s, sweep_en_s;
    logic [IDX_BITS-1:0] widx_s;
    tlb_entry_t          wentry_s;
    tlb_entry_t          rd_s;
    logic                probe_hit_s, probe_multi_s;
    logic [IDX_BITS-1:0] probe_idx_s;
    logic                unused_s;

    assign unused_s      = ^{entryhi_i[12:8], entrylo0_i[31:26], entrylo1_i[31:26]};
    assign cmd_ready     = (state_r == ST_IDLE);
    assign random_o      = random_r;
    assign probe_index_o = probe_r;
    assign multi_hit_o   = multi_r;

    assign rd_s       = entries_r[index_i];
    assign mask_o     = rd_s.mask;
    assign entryhi_o  = {rd_s.vpn2, 5'b00000, rd_s.asid};
    assign entrylo0_o = {6'b000000, rd_s.pfn0, rd_s.c0, rd_s.d0, rd_s.v0, rd_s.g};
    assign entrylo1_o = {6'b000000, rd_s.pfn1, rd_s.c1, rd_s.d1, rd_s.v1, rd_s.g};

    // Write image: page-number bits covered by the mask are stored as zero
    always_comb begin
        wentry_s      = ENTRY_RESET;
        wentry_s.mask = mask_i;
        wentry_s.vpn2 = entryhi_i[31:13] & ~{7'b0000000, mask_i};
        wentry_s.asid = entryhi_i[7:0];
        wentry_s.g    = entrylo0_i[0] & entrylo1_i[0];
        wentry_s.pfn0 = entrylo0_i[25:6] & ~{8'h00, mask_i};
        wentry_s.pfn1 = entrylo1_i[25:6] & ~{8'h00, mask_i};
        wentry_s.c0   = entrylo0_i[5:3];
        wentry_s.c1   = entrylo1_i[5:3];
        wentry_s.d0   = entrylo0_i[2];
        wentry_s.d1   = entrylo1_i[2];
        wentry_s.v0   = entrylo0_i[1];
        wentry_s.v1   = entrylo1_i[1];
    end

    // Probe search against EntryHi; a second hit flags a duplicate
    always_comb begin
        probe_hit_s   = 1'b0;
        probe_multi_s = 1'b0;
        probe_idx_s   = '0;
        for (int i = TLB_NUM - 1; i >= 0; i--) begin
            if (tlb_match(entries_r[i], live_r[i], entryhi_i, entryhi_i[7:0])) begin
                probe_multi_s = probe_multi_s | probe_hit_s;
                probe_hit_s   = 1'b1;
                probe_idx_s   = IDX_BITS'(i);
            end else begin
                probe_hit_s   = probe_hit_s;
            end
        end
    end

    // Command FSM next-state and strobes
    always_comb begin
        state_s    = state_r;
        we_s       = 1'b0;
        widx_s     = index_i;
        probe_en_s = 1'b0;
        sweep_en_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (tlb_op_t'(cmd_op))
                        OP_TLBWI:  we_s = 1'b1;
                        OP_TLBWR:  begin we_s = 1'b1; widx_s = random_r; end
                        OP_TLBP:   probe_en_s = 1'b1;
                        OP_INVALL: state_s = ST_SWEEP;
                        default:   state_s = ST_IDLE;
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                sweep_en_s = 1'b1;
                state_s    = (sweep_cnt_r == LAST) ? ST_IDLE : ST_SWEEP;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM state and sweep position
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            sweep_cnt_r <= '0;
        end else begin
            state_r     <= state_s;
            sweep_cnt_r <= (state_r == ST_SWEEP) ? sweep_cnt_r + 1'b1 : '0;
        end
    end

    // Entry array: single write or one sweep clear per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TLB_NUM; i++) begin
                entries_r[i] <= ENTRY_RESET;
            end
            live_r <= '0;
        end else if (we_s) begin
            entries_r[widx_s] <= wentry_s;
            live_r[widx_s]    <= 1'b1;
        end else if (sweep_en_s) begin
            entries_r[sweep_cnt_r].v0 <= 1'b0;
            entries_r[sweep_cnt_r].v1 <= 1'b0;
            entries_r[sweep_cnt_r].g  <= 1'b0;
            live_r[sweep_cnt_r]       <= 1'b0;
        end else begin
            live_r <= live_r;
        end
    end

    // Random wraps before stepping onto the wired boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            random_r <= LAST;
        end else if ({1'b0, random_r} <= ({1'b0, wired_i} + (IDX_BITS+1)'(1))) begin
            random_r <= LAST;
        end else begin
            random_r <= random_r - 1'b1;
        end
    end

    // Probe result and sticky duplicate flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            probe_r <= 32'h8000_0000;
            multi_r <= 1'b0;
        end else if (probe_en_s) begin
            probe_r <= {~probe_hit_s, {(31-IDX_BITS){1'b0}}, probe_idx_s};
            multi_r <= multi_r | probe_multi_s;
        end else begin
            probe_r <= probe_r;
            multi_r <= multi_r;
        end
    end

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        tlb_lookup_port #(.TLB_NUM(TLB_NUM)) u_port (
            .clk     (clk),
            .rst     (rst),
            .va      (lk_va_i[p*32 +: 32]),
            .asid    (entryhi_i[7:0]),
            .stall   (lk_stall_i[p]),
            .flush   (lk_flush_i[p]),
            .entries (entries_r),
            .live    (live_r),
            .pa      (lk_pa_o[p*32 +: 32]),
            .exc     (lk_exc_o[p*3 +: 3]),
            .cca     (lk_cca_o[p*3 +: 3])
        );
    end

endmodule
